// File: rtl/tca_histogram_ctrl.sv
// Time-correlation histogram sequencer: owns the bin RAM and runs clear,
// windowed acquisition (read-modify-write with forwarding) and bin readout.
module tca_histogram_ctrl #(
  parameter int BIN_ADDR_W = 8,
  parameter int CNT_W      = 8,
  parameter int LEN_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  input  logic [1:0]            cmd_i,
  output logic                  cmd_ready_o,
  input  logic [LEN_W-1:0]      acq_len_i,
  input  logic                  evt_valid_i,
  input  logic [BIN_ADDR_W-1:0] evt_bin_i,
  output logic [BIN_ADDR_W-1:0] mem_addr_o,
  output logic [BIN_ADDR_W-1:0] mem_raddr_o,
  output logic                  mem_rd_en_o,
  input  logic [CNT_W-1:0]      mem_rdata_i,
  output logic                  mem_wr_en_o,
  output logic [CNT_W-1:0]      mem_wdata_o,
  output logic [CNT_W-1:0]      rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic                  rd_last_o,
  output logic                  acq_done_o,
  output logic                  sat_flag_o,
  output logic [15:0]           drop_cnt_o
);

  // state        | meaning
  // S_IDLE       | accept host command
  // S_CLEAR      | write 0 to every bin, one per cycle
  // S_ACQ        | window running, events enter the RMW pipeline
  // S_DRAIN      | finish last increment, pulse acq_done
  // S_RD_ISSUE   | read bin at addr_q
  // S_RD_WAIT    | capture read data
  // S_RD_PRESENT | hold bin on rd_data until rd_ready
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACQ, S_DRAIN, S_RD_ISSUE, S_RD_WAIT, S_RD_PRESENT
  } state_e;

  localparam logic [BIN_ADDR_W-1:0] LAST_BIN = '1;
  localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
  localparam logic [15:0]           DROP_MAX = 16'hFFFF;

  state_e                  state_q, state_d;
  logic [BIN_ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]        win_q, win_d;
  logic                    p1_valid_q, p1_valid_d;
  logic [BIN_ADDR_W-1:0]   p1_bin_q, p1_bin_d;
  logic                    fw_valid_q, fw_valid_d;
  logic [BIN_ADDR_W-1:0]   fw_addr_q, fw_addr_d;
  logic [CNT_W-1:0]        fw_data_q, fw_data_d;
  logic [CNT_W-1:0]        rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    sat_q, sat_d;
  logic [15:0]             drop_q, drop_d;

  logic                    evt_acc;
  logic                    clr_stats;
  logic [CNT_W-1:0]        operand;
  logic [CNT_W-1:0]        incr;

  // The previous cycle's write is not yet visible through the read-first RAM.
  always_comb begin
    operand = (fw_valid_q && (fw_addr_q == p1_bin_q)) ? fw_data_q : mem_rdata_i;
    incr    = (operand == CNT_MAX) ? operand : operand + CNT_W'(1);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    win_d       = win_q;
    p1_valid_d  = 1'b0;
    p1_bin_d    = p1_bin_q;
    fw_valid_d  = 1'b0;
    fw_addr_d   = fw_addr_q;
    fw_data_d   = fw_data_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    sat_d       = sat_q;
    drop_d      = drop_q;
    cmd_ready_o = 1'b0;
    mem_addr_o  = '0;
    mem_raddr_o = '0;
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_wdata_o = '0;
    acq_done_o  = 1'b0;
    evt_acc     = 1'b0;
    clr_stats   = 1'b0;

    if (p1_valid_q) begin
      mem_wr_en_o = 1'b1;
      mem_addr_o  = p1_bin_q;
      mem_wdata_o = incr;
      fw_valid_d  = 1'b1;
      fw_addr_d   = p1_bin_q;
      fw_data_d   = incr;
      if (operand == CNT_MAX) sat_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          case (cmd_i)
            2'b01: begin
              state_d   = S_CLEAR;
              addr_d    = '0;
              clr_stats = 1'b1;
            end
            2'b10: begin
              state_d = S_ACQ;
              win_d   = acq_len_i;
            end
            2'b11: begin
              state_d = S_RD_ISSUE;
              addr_d  = '0;
            end
            default: ;
          endcase
        end
      end
      S_CLEAR: begin
        mem_wr_en_o = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = '0;
        addr_d      = addr_q + BIN_ADDR_W'(1);
        if (addr_q == LAST_BIN) state_d = S_IDLE;
      end
      S_ACQ: begin
        if (evt_valid_i && (win_q != '0)) begin
          evt_acc     = 1'b1;
          mem_rd_en_o = 1'b1;
          mem_raddr_o = evt_bin_i;
          p1_valid_d  = 1'b1;
          p1_bin_d    = evt_bin_i;
        end
        if (win_q != '0) win_d = win_q - LEN_W'(1);
        if (win_q <= LEN_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        acq_done_o = 1'b1;
        state_d    = S_IDLE;
      end
      S_RD_ISSUE: begin
        mem_rd_en_o = 1'b1;
        mem_raddr_o = addr_q;
        mem_addr_o  = addr_q;
        state_d     = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rd_data_d  = mem_rdata_i;
        rd_valid_d = 1'b1;
        state_d    = S_RD_PRESENT;
      end
      S_RD_PRESENT: begin
        if (rd_ready_i) begin
          rd_valid_d = 1'b0;
          if (addr_q == LAST_BIN) begin
            state_d = S_IDLE;
          end else begin
            addr_d  = addr_q + BIN_ADDR_W'(1);
            state_d = S_RD_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (evt_valid_i && !evt_acc && (drop_q != DROP_MAX)) drop_d = drop_q + 16'd1;
    if (clr_stats) begin
      sat_d  = 1'b0;
      drop_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      win_q      <= '0;
      p1_valid_q <= 1'b0;
      p1_bin_q   <= '0;
      fw_valid_q <= 1'b0;
      fw_addr_q  <= '0;
      fw_data_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      sat_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      win_q      <= win_d;
      p1_valid_q <= p1_valid_d;
      p1_bin_q   <= p1_bin_d;
      fw_valid_q <= fw_valid_d;
      fw_addr_q  <= fw_addr_d;
      fw_data_q  <= fw_data_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      sat_q      <= sat_d;
      drop_q     <= drop_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_last_o  = rd_valid_q && (addr_q == LAST_BIN);
  assign sat_flag_o = sat_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_tca_histogram_ctrl.sv
// Directed bench for tca_histogram_ctrl: read-first RAM model, readout
// scoreboard checked by an independent monitor, hand-computed bin values.
module tb_tca_histogram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        cmd_ready;
  logic [31:0] acq_len = '0;
  logic        evt_valid = 1'b0;
  logic [7:0]  evt_bin = '0;
  logic [7:0]  mem_addr, mem_raddr, mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_rd_en, mem_wr_en;
  logic [7:0]  rd_data;
  logic        rd_valid, rd_last, acq_done, sat_flag;
  logic        rd_ready = 1'b0;
  logic [15:0] drop_cnt;

  logic [7:0]  ram [0:255];
  logic        scrub = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          wr_cnt = 0;
  int          exp_bins [0:255];
  logic [8:0]  exp_q [$];
  int          ev_q [$];
  logic [8:0]  mon_e;
  bit          stalled = 1'b0;
  logic [7:0]  held = '0;

  always #5 clk = ~clk;

  tca_histogram_ctrl #(.BIN_ADDR_W(8), .CNT_W(8), .LEN_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_i(cmd), .cmd_ready_o(cmd_ready),
    .acq_len_i(acq_len), .evt_valid_i(evt_valid), .evt_bin_i(evt_bin),
    .mem_addr_o(mem_addr), .mem_raddr_o(mem_raddr), .mem_rd_en_o(mem_rd_en),
    .mem_rdata_i(mem_rdata), .mem_wr_en_o(mem_wr_en), .mem_wdata_o(mem_wdata),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_last_o(rd_last), .acq_done_o(acq_done), .sat_flag_o(sat_flag),
    .drop_cnt_o(drop_cnt)
  );

  // Read-first RAM; scrub fills it with garbage so a missing clear shows up.
  always @(posedge clk) begin
    if (scrub) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'hA5;
    end else begin
      if (mem_rd_en) mem_rdata <= ram[mem_raddr];
      if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_valid && stalled) chk("rd_stable", 32'(rd_data), 32'(held));
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("rd_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(mon_e[7:0]));
          chk("rd_last", 32'(rd_last), 32'(mon_e[8]));
        end
      end
      stalled = rd_valid && !rd_ready;
      held    = rd_data;
      if (acq_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (mem_wr_en) wr_cnt++;
    end
  end

  task automatic issue_cmd(input logic [1:0] c, input int len);
    int n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) chk("cmd_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd       = c;
    acq_len   = 32'(len);
    acc_cyc   = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd       = 2'b00;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (!cmd_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_clear();
    int lowc = 0;
    int widx = 0;
    int n = 0;
    issue_cmd(2'b01, 0);
    while (n < 400) begin
      @(negedge clk);
      if (cmd_ready) break;
      lowc++;
      if (mem_wr_en) begin
        chk("clr_wr", 32'({mem_addr, mem_wdata}), 32'({widx[7:0], 8'h00}));
        widx++;
      end
      n++;
    end
    chk("clr_busy_cycles", 32'(lowc), 32'd256);
    chk("clr_writes", 32'(widx), 32'd256);
    for (int i = 0; i < 256; i++) exp_bins[i] = 0;
  endtask

  task automatic run_acq(input int len);
    int base = done_cnt;
    issue_cmd(2'b10, len);
    foreach (ev_q[i]) begin
      evt_valid = 1'b1;
      evt_bin   = 8'(ev_q[i]);
      @(posedge clk); #1;
    end
    evt_valid = 1'b0;
    wait_idle("acq_idle");
    chk("acq_done_cnt", 32'(done_cnt - base), 32'd1);
    chk("acq_done_lat", 32'(done_cyc - acc_cyc), 32'(len + 1));
    ev_q.delete();
  endtask

  task automatic readout(input bit toggle);
    int n = 0;
    for (int i = 0; i < 256; i++) exp_q.push_back({(i == 255), 8'(exp_bins[i])});
    rd_ready = ~toggle;
    issue_cmd(2'b11, 0);
    while (!(exp_q.size() == 0 && cmd_ready) && n < 3000) begin
      @(posedge clk); #1;
      if (toggle) rd_ready = ~rd_ready;
      n++;
    end
    chk("rd_remaining", 32'(exp_q.size()), 32'd0);
    chk("rd_idle", 32'(cmd_ready), 32'd1);
    exp_q.delete();
    rd_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_base;
    for (int i = 0; i < 256; i++) exp_bins[i] = 0;

    // Reset values
    scrub = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_outputs", 32'({rd_valid, rd_last, mem_wr_en, mem_rd_en, acq_done, sat_flag}), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    scrub = 1'b0;
    rst_n = 1'b1;

    // Clear, then every bin reads back 0
    do_clear();
    readout(1'b0);

    // 10 events into bin 5
    for (int i = 0; i < 10; i++) ev_q.push_back(5);
    run_acq(10);
    exp_bins[5] = 10;
    readout(1'b0);

    // Back-to-back same-bin hazard
    ev_q.push_back(3); ev_q.push_back(3); ev_q.push_back(7); ev_q.push_back(3);
    run_acq(4);
    exp_bins[3] = 3;
    exp_bins[7] = 1;
    readout(1'b0);
    chk("drop_none", 32'(drop_cnt), 32'd0);
    chk("sat_none", 32'(sat_flag), 32'd0);

    // Saturation
    do_clear();
    for (int i = 0; i < 300; i++) ev_q.push_back(9);
    run_acq(300);
    exp_bins[9] = 255;
    chk("sat_set", 32'(sat_flag), 32'd1);
    readout(1'b0);
    do_clear();
    chk("sat_cleared", 32'(sat_flag), 32'd0);

    // Dropped events in IDLE and during a stalled readout
    @(posedge clk); #1;
    evt_valid = 1'b1;
    evt_bin   = 8'd1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    evt_valid = 1'b0;
    chk("drop_idle", 32'(drop_cnt), 32'd2);
    wr_base = wr_cnt;
    fork
      readout(1'b1);
      begin
        repeat (10) @(posedge clk);
        #1;
        evt_valid = 1'b1;
        evt_bin   = 8'd4;
        repeat (2) begin
          @(posedge clk); #1;
        end
        evt_valid = 1'b0;
      end
    join
    chk("drop_total", 32'(drop_cnt), 32'd4);
    chk("rd_no_writes", 32'(wr_cnt - wr_base), 32'd0);

    // Reset in the middle of an acquisition
    wr_base = done_cnt;
    issue_cmd(2'b10, 50);
    evt_valid = 1'b1;
    evt_bin   = 8'd2;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_outputs", 32'({rd_valid, mem_wr_en, mem_rd_en, acq_done, sat_flag}), 32'd0);
    chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
    evt_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("mid_rst_no_done", 32'(done_cnt - wr_base), 32'd0);
    chk("mid_rst_idle", 32'(cmd_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
